// File: rtl/layer_compositor_fade_if.sv
// Pixel-path bundle between the layer drawers and the compositor.
// Producer side drives layers; compositor returns the VGA colour.
interface layer_compositor_fade_if #(
  parameter int NUM_LAYERS = 4
);
  localparam int WW = $clog2(NUM_LAYERS + 1);

  logic [NUM_LAYERS-1:0]   layer_dr;
  logic [8*NUM_LAYERS-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]   layer_en;
  logic [7:0]              background_rgb;
  logic [7:0]              redOut;
  logic [7:0]              greenOut;
  logic [7:0]              blueOut;
  logic [WW-1:0]           winner_idx;

  modport master (
    output layer_dr,
    output layer_rgb,
    output layer_en,
    output background_rgb,
    input  redOut,
    input  greenOut,
    input  blueOut,
    input  winner_idx
  );

  modport slave (
    input  layer_dr,
    input  layer_rgb,
    input  layer_en,
    input  background_rgb,
    output redOut,
    output greenOut,
    output blueOut,
    output winner_idx
  );
endinterface

// File: rtl/layer_compositor_fade.sv
// N-layer priority compositor with colour key, enable mask,
// 2-stage pixel pipeline and frame-synchronous fade engine.
module layer_compositor_fade #(
  parameter int         NUM_LAYERS       = 4,
  parameter logic [7:0] TRANSPARENT_KEY  = 8'hFF,
  parameter int         FADE_STEP_FRAMES = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic fade_out_req,
  input  logic fade_in_req,
  layer_compositor_fade_if.slave pix,
  output logic [3:0] fade_level,
  output logic       fade_busy
);
  localparam int WW = $clog2(NUM_LAYERS + 1);
  localparam int CW = $clog2(FADE_STEP_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(FADE_STEP_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE, FADE_OUT, BLACK, FADE_IN
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_out_q, pend_out_d;
  logic          pend_in_q, pend_in_d;

  logic [7:0]    rgb1_q, rgb1_d;
  logic [WW-1:0] win1_q, win1_d;
  logic [7:0]    red_q, red_d;
  logic [7:0]    grn_q, grn_d;
  logic [7:0]    blu_q, blu_d;
  logic [WW-1:0] win2_q, win2_d;

  logic [NUM_LAYERS-1:0] valid;
  logic [7:0]  r8, g8, b8;
  logic [11:0] pr, pg, pb;

  // Scan high to low so the lowest valid index overwrites last
  always_comb begin
    valid  = '0;
    rgb1_d = pix.background_rgb;
    win1_d = WW'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      valid[i] = pix.layer_dr[i] & pix.layer_en[i]
               & (pix.layer_rgb[8*i +: 8] != TRANSPARENT_KEY);
      if (valid[i]) begin
        rgb1_d = pix.layer_rgb[8*i +: 8];
        win1_d = WW'(i);
      end
    end
  end

  always_comb begin
    r8 = {rgb1_q[7:5], rgb1_q[7:5], rgb1_q[7:6]};
    g8 = {rgb1_q[4:2], rgb1_q[4:2], rgb1_q[4:3]};
    b8 = {4{rgb1_q[1:0]}};
    pr = 12'(r8) * 12'(level_q);
    pg = 12'(g8) * 12'(level_q);
    pb = 12'(b8) * 12'(level_q);
    red_d  = 8'(pr >> 3);
    grn_d  = 8'(pg >> 3);
    blu_d  = 8'(pb >> 3);
    win2_d = win1_q;
  end

  // Requests arriving with startOfFrame wait for the next frame
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    pend_out_d = pend_out_q | fade_out_req;
    pend_in_d  = pend_in_q | fade_in_req;
    if (startOfFrame) begin
      pend_out_d = fade_out_req;
      pend_in_d  = fade_in_req;
      unique case (state_q)
        IDLE: begin
          if (pend_out_q) begin
            state_d = FADE_OUT;
            cnt_d   = '0;
          end
        end
        FADE_OUT: begin
          if (pend_in_q) begin
            state_d = FADE_IN;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            level_d = level_q - 4'd1;
            if (level_q == 4'd1) state_d = BLACK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BLACK: begin
          if (pend_in_q) begin
            state_d = FADE_IN;
            cnt_d   = '0;
          end
        end
        FADE_IN: begin
          if (pend_out_q) begin
            state_d = FADE_OUT;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            level_d = level_q + 4'd1;
            if (level_q == 4'd7) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      level_q    <= 4'd8;
      cnt_q      <= '0;
      pend_out_q <= 1'b0;
      pend_in_q  <= 1'b0;
      rgb1_q     <= '0;
      win1_q     <= '0;
      red_q      <= '0;
      grn_q      <= '0;
      blu_q      <= '0;
      win2_q     <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      pend_out_q <= pend_out_d;
      pend_in_q  <= pend_in_d;
      rgb1_q     <= rgb1_d;
      win1_q     <= win1_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
      blu_q      <= blu_d;
      win2_q     <= win2_d;
    end
  end

  assign pix.redOut     = red_q;
  assign pix.greenOut   = grn_q;
  assign pix.blueOut    = blu_q;
  assign pix.winner_idx = win2_q;
  assign fade_level     = level_q;
  assign fade_busy      = (state_q == FADE_OUT)
                        | (state_q == FADE_IN);
endmodule

// File: tb/tb_layer_compositor_fade.sv
// Bench for layer_compositor_fade: vector table through a
// latency-tagged scoreboard, then fade/reset sequences.
module tb_layer_compositor_fade;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic fade_out_req = 1'b0;
  logic fade_in_req = 1'b0;
  logic [3:0] fade_level;
  logic fade_busy;

  layer_compositor_fade_if #(.NUM_LAYERS(4)) pif ();

  layer_compositor_fade #(
    .NUM_LAYERS(4),
    .TRANSPARENT_KEY(8'hFF),
    .FADE_STEP_FRAMES(4)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .fade_out_req(fade_out_req),
    .fade_in_req(fade_in_req),
    .pix(pif.slave),
    .fade_level(fade_level),
    .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dr;
    logic [3:0]  en;
    logic [31:0] rgb;
    logic [7:0]  bg;
    logic [7:0]  er;
    logic [7:0]  eg;
    logic [7:0]  eb;
    logic [2:0]  ew;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [2:0] w;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("red", int'(pif.redOut), int'(e.r));
      chk("green", int'(pif.greenOut), int'(e.g));
      chk("blue", int'(pif.blueOut), int'(e.b));
      chk("winner", int'(pif.winner_idx), int'(e.w));
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    pif.layer_dr       = v.dr;
    pif.layer_en       = v.en;
    pif.layer_rgb      = v.rgb;
    pif.background_rgb = v.bg;
    e.due = cyc + 2;
    e.r = v.er;
    e.g = v.eg;
    e.b = v.eb;
    e.w = v.ew;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic sof(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic req(input logic o, input logic i);
    tick();
    fade_out_req = o;
    fade_in_req  = i;
    tick();
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
  endtask

  task automatic lvl(input string nm, input int l, input int b);
    chk({nm, "_level"}, int'(fade_level), l);
    chk({nm, "_busy"}, int'(fade_busy), b);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{4'b0101, 4'hF, 32'h001C_00E0, 8'h00,
               8'hFF, 8'h00, 8'h00, 3'd0};
    tbl[1] = '{4'b0011, 4'hF, 32'h0000_03FF, 8'h00,
               8'h00, 8'h00, 8'hFF, 3'd1};
    tbl[2] = '{4'b0000, 4'hF, 32'h1C1C_1C1C, 8'h49,
               8'h49, 8'h49, 8'h55, 3'd4};
    tbl[3] = '{4'b0001, 4'hE, 32'h0000_00E0, 8'h49,
               8'h49, 8'h49, 8'h55, 3'd4};
    tbl[4] = '{4'b1000, 4'hF, 32'h1C00_0000, 8'h00,
               8'h00, 8'hFF, 8'h00, 3'd3};
    tbl[5] = '{4'b1100, 4'hF, 32'h92FF_0000, 8'h00,
               8'h92, 8'h92, 8'hAA, 3'd3};
    tbl[6] = '{4'b1111, 4'h6, 32'h1C00_6DE0, 8'h00,
               8'h6D, 8'h6D, 8'h55, 3'd1};
    tbl[7] = '{4'b0001, 4'hF, 32'h0000_0000, 8'hFF,
               8'h00, 8'h00, 8'h00, 3'd0};

    pif.layer_dr = '0;
    pif.layer_en = '0;
    pif.layer_rgb = '0;
    pif.background_rgb = '0;

    tick();
    tick();
    chk("rst_red", int'(pif.redOut), 0);
    chk("rst_winner", int'(pif.winner_idx), 0);
    lvl("rst", 8, 0);
    resetN = 1'b1;

    for (int k = 0; k < 8; k++) begin
      tick();
      drive(tbl[k]);
    end
    drain();

    // fade out to black, white check at level 4
    req(1'b1, 1'b0);
    sof(1);
    lvl("t4_start", 8, 1);
    sof(16);
    lvl("t4_mid", 4, 1);
    tick();
    v = '{4'b0000, 4'hF, 32'h0, 8'hFF,
          8'h7F, 8'h7F, 8'h7F, 3'd4};
    drive(v);
    drain();
    sof(16);
    lvl("t4_black", 0, 0);
    sof(2);
    lvl("t4_hold", 0, 0);
    tick();
    v = '{4'b0001, 4'hF, 32'h0000_00E0, 8'h00,
          8'h00, 8'h00, 8'h00, 3'd0};
    drive(v);
    drain();
    req(1'b0, 1'b1);
    sof(1);
    lvl("t4_in_start", 0, 1);
    sof(4);
    lvl("t4_in1", 1, 1);
    sof(28);
    lvl("t4_full", 8, 0);
    sof(1);
    lvl("t4_idle", 8, 0);

    // both requests in IDLE -> out wins; then reverse at 5
    req(1'b1, 1'b1);
    sof(1);
    lvl("t5_out", 8, 1);
    sof(12);
    lvl("t5_l5", 5, 1);
    req(1'b0, 1'b1);
    sof(1);
    lvl("t5_rev", 5, 1);
    sof(4);
    lvl("t5_up", 6, 1);
    // request coincident with SOF is deferred one frame
    tick();
    startOfFrame = 1'b1;
    fade_out_req = 1'b1;
    tick();
    startOfFrame = 1'b0;
    fade_out_req = 1'b0;
    sof(3);
    lvl("t5_defer", 6, 1);
    sof(1);
    lvl("t5_back", 6, 1);
    sof(12);
    lvl("t6_l3", 3, 1);

    // asynchronous reset mid-fade
    pif.background_rgb = 8'hFF;
    pif.layer_dr = '0;
    drain();
    chk("t6_pre_red", int'(pif.redOut), 8'h5F);
    #2 resetN = 1'b0;
    #1;
    lvl("t6_rst", 8, 0);
    chk("t6_red", int'(pif.redOut), 0);
    chk("t6_green", int'(pif.greenOut), 0);
    chk("t6_blue", int'(pif.blueOut), 0);
    chk("t6_winner", int'(pif.winner_idx), 0);
    tick();
    resetN = 1'b1;
    sof(2);
    lvl("t6_after", 8, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
